fp16_calc_sequencer: RTL and testbench
======================================

Name: fp16_calc_sequencer

Overview:
Sequences the FP16 add/subtract calculator datapath.
- Captures keypad values into operand registers A and B on button events.
- Freezes the operands and operation, then waits a fixed settle time for the combinational adder/normaliser.
- Captures the result into register C.
- Requests an LCD refresh through a req/ack handshake.
- Sits between the keypad/button front end and the FP16 adder and LCD blocks.

Parameters:
SETTLE_CYCLES, 3, number of cycles operands/op are held stable before the result is captured (1..15)
KEY_SYNC, 1, 1 = two-flop synchronise key_*/clear_* inputs before edge detect; 0 = use directly

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
key_a  input  1  load-A button, level; rising edge = event
key_b  input  1  load-B button, level; rising edge = event
key_c  input  1  compute button, level; rising edge = event
clear_a  input  1  clear A, level; rising edge = event
clear_b  input  1  clear B, level; rising edge = event
op_in  input  1  1 = add, 0 = subtract; sampled at compute start
keypad_val  input  16  current keypad entry (FP16 pattern)
res_in  input  16  datapath result {sign, exp[4:0], mant[9:0]}
lcd_ack  input  1  LCD has accepted the refresh request
op_a  output  16  operand A to datapath
op_b  output  16  operand B to datapath
op_sel  output  1  latched operation to datapath
reg_c  output  16  captured result
flag_a  output  1  A holds a loaded value
flag_b  output  1  B holds a loaded value
flag_c  output  1  reg_c valid
busy  output  1  high in SETTLE, CAPTURE and LCD_WAIT
lcd_req  output  1  LCD refresh request

Behaviour:
- Reset (async assert, sync release): all outputs 0, op_sel = 1, FSM = IDLE, edge-detect history = 0 so a key held through reset produces no event.
- Edge detect: event = input & ~previous (after the optional sync stage). Each event is a one-cycle pulse.
- FSM states: IDLE, SETTLE, CAPTURE, LCD_WAIT.
- IDLE, at most one event acted on per cycle, priority clear_a > clear_b > key_c > key_a > key_b. Lower-priority events in the same cycle are dropped.
  - clear_a: op_a = 0, flag_a = 0, flag_c = 0, go to LCD_WAIT.
  - clear_b: op_b = 0, flag_b = 0, flag_c = 0, go to LCD_WAIT.
  - key_a: op_a = keypad_val, flag_a = 1, go to LCD_WAIT.
  - key_b: op_b = keypad_val, flag_b = 1, go to LCD_WAIT.
  - key_c with flag_a & flag_b: op_sel = op_in, counter = SETTLE_CYCLES-1, go to SETTLE.
  - key_c without both flags: ignored, stay IDLE.
- SETTLE: counter decrements each cycle. At 0, go to CAPTURE. op_a, op_b and op_sel do not change.
- CAPTURE (1 cycle): reg_c = res_in (or the special value, see Optional Feature), flag_c = 1, go to LCD_WAIT.
  - Latency from key_c event cycle to reg_c valid = SETTLE_CYCLES + 1 cycles.
- LCD_WAIT:
  - lcd_req = 1 on the cycle of entry.
  - Held until lcd_ack is sampled high. lcd_req drops the following cycle and the FSM returns to IDLE.
  - lcd_ack while not in LCD_WAIT is ignored.
- Busy handling:
  - key_a/b/c events while busy are discarded (not queued).
  - clear_a/clear_b during SETTLE abort the compute: apply the clear, no capture, flag_c = 0, go to LCD_WAIT.
  - Clears during CAPTURE/LCD_WAIT are discarded.
- op_sel changes only at compute start; op_in toggling otherwise has no effect.

Optional Feature:
FP16_SPECIAL_EN
- Defined, CAPTURE overrides res_in with these rules in order:
  - either operand exponent == 5'h1F: reg_c = 16'h7E00.
  - op_a[14:0] == 0: reg_c = op_b, sign inverted when op_sel = 0.
  - op_b[14:0] == 0: reg_c = op_a.
- Not defined: reg_c = res_in always. Special-case logic is absent.

Test Plan:
1. key_a with keypad_val=16'h3C00, ack after 2 cycles -> op_a=16'h3C00, flag_a=1, lcd_req high exactly until the cycle after ack.
2. Load A=16'h3C00, B=16'h4000, op_in=1, key_c, SETTLE_CYCLES=3, res_in=16'h4200 -> reg_c=16'h4200 four cycles after the key_c event, flag_c=1, busy high throughout.
3. key_c with only A loaded -> no state change, lcd_req stays 0, reg_c unchanged.
4. clear_b asserted two cycles into SETTLE -> op_b=0, flag_b=0, flag_c=0, no capture, lcd_req raised.
5. key_a and key_b rising in the same IDLE cycle -> only op_a loaded. Later key_b while in LCD_WAIT -> ignored.
6. FP16_SPECIAL_EN, A=16'h7C00, B=16'h3C00, compute -> reg_c=16'h7E00. A=0, B=16'h4000, op_in=0 -> reg_c=16'hC000.

Source files
------------

// File: rtl/fp16_calc_sequencer_if.sv
// fp16_calc_sequencer_if -- bundles the keypad/button front end, the FP16
// datapath operand/result bus and the LCD refresh handshake. The sequencer
// attaches through the master modport. An environment that drives the buttons
// and observes the operands attaches through the slave modport.
interface fp16_calc_sequencer_if;
  // front end -> sequencer
  logic        key_a;
  logic        key_b;
  logic        key_c;
  logic        clear_a;
  logic        clear_b;
  logic        op_in;
  logic [15:0] keypad_val;
  // datapath / LCD -> sequencer
  logic [15:0] res_in;
  logic        lcd_ack;
  // sequencer -> datapath / LCD / status
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic        op_sel;
  logic [15:0] reg_c;
  logic        flag_a;
  logic        flag_b;
  logic        flag_c;
  logic        busy;
  logic        lcd_req;

  modport master (
    input  key_a, key_b, key_c, clear_a, clear_b, op_in, keypad_val,
    input  res_in, lcd_ack,
    output op_a, op_b, op_sel, reg_c, flag_a, flag_b, flag_c, busy, lcd_req
  );

  modport slave (
    output key_a, key_b, key_c, clear_a, clear_b, op_in, keypad_val,
    output res_in, lcd_ack,
    input  op_a, op_b, op_sel, reg_c, flag_a, flag_b, flag_c, busy, lcd_req
  );
endinterface

// File: rtl/fp16_calc_sequencer.sv
// fp16_calc_sequencer -- control sequencer for the FP16 add/subtract
// calculator. It loads or clears operands A and B on button events. On a
// compute request it freezes the operands and the operation, waits
// SETTLE_CYCLES for the combinational adder, captures the result into C and
// then asks the LCD to refresh through a req/ack handshake.
// Optional build macro: FP16_SPECIAL_EN. When defined, the capture step
// replaces the datapath result for NaN/Inf operands and for zero operands.
module fp16_calc_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 3,    // 1..15
  parameter bit          KEY_SYNC      = 1'b1
) (
  input  logic                         clk,
  input  logic                         reset,  // async, active low
  fp16_calc_sequencer_if.master        bus
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_SETTLE   = 2'd1;
  localparam logic [1:0] ST_CAPTURE  = 2'd2;
  localparam logic [1:0] ST_LCD_WAIT = 2'd3;

  localparam logic [3:0] CNT_INIT  = 4'(SETTLE_CYCLES - 1);
  // Number of clocks after reset before the edge-detect history reflects the
  // real button levels: the synchroniser depth plus the history flop.
  localparam logic [1:0] ARM_DEPTH = KEY_SYNC ? 2'd3 : 2'd1;

  // Button bit order: {clear_a, clear_b, key_c, key_a, key_b}.
  logic [4:0]  keys_raw;
  logic [4:0]  keys_s;
  logic [4:0]  hist_q, hist_d;
  logic [4:0]  events;
  logic [1:0]  arm_cnt_q, arm_cnt_d;
  logic        armed;
  logic        ev_clr_a, ev_clr_b, ev_key_c, ev_key_a, ev_key_b;

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] op_a_q, op_a_d;
  logic [15:0] op_b_q, op_b_d;
  logic        op_sel_q, op_sel_d;
  logic [15:0] reg_c_q, reg_c_d;
  logic        flag_a_q, flag_a_d;
  logic        flag_b_q, flag_b_d;
  logic        flag_c_q, flag_c_d;
  logic [15:0] cap_val;

  assign keys_raw = {bus.clear_a, bus.clear_b, bus.key_c, bus.key_a, bus.key_b};

  generate
    if (KEY_SYNC) begin : g_sync
      logic [4:0] sync1_q, sync2_q;
      // Two-flop synchroniser for the asynchronous button levels.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          sync1_q <= '0;
          sync2_q <= '0;
        end else begin
          sync1_q <= keys_raw;
          sync2_q <= sync1_q;
        end
      end
      assign keys_s = sync2_q;
    end else begin : g_nosync
      assign keys_s = keys_raw;
    end
  endgenerate

  // A button held through reset must not look like a fresh press. The history
  // clears to zero, so events stay masked until it has sampled real levels.
  assign armed    = (arm_cnt_q == ARM_DEPTH);
  assign events   = keys_s & ~hist_q & {5{armed}};
  assign ev_clr_a = events[4];
  assign ev_clr_b = events[3];
  assign ev_key_c = events[2];
  assign ev_key_a = events[1];
  assign ev_key_b = events[0];

  // Value written into C at capture time.
`ifdef FP16_SPECIAL_EN
  always_comb begin
    cap_val = bus.res_in;
    if (op_a_q[14:10] == 5'h1F || op_b_q[14:10] == 5'h1F) begin
      cap_val = 16'h7E00;                                  // quiet NaN
    end else if (op_a_q[14:0] == 15'd0) begin
      cap_val = op_sel_q ? op_b_q : {~op_b_q[15], op_b_q[14:0]};
    end else if (op_b_q[14:0] == 15'd0) begin
      cap_val = op_a_q;
    end
  end
`else
  assign cap_val = bus.res_in;
`endif

  // Next-state logic: edge-detect history, operand registers and the FSM.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    hist_d    = keys_s;
    arm_cnt_d = armed ? arm_cnt_q : arm_cnt_q + 2'd1;
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    op_sel_d  = op_sel_q;
    reg_c_d   = reg_c_q;
    flag_a_d  = flag_a_q;
    flag_b_d  = flag_b_q;
    flag_c_d  = flag_c_q;

    case (state_q)
      ST_IDLE: begin
        // At most one event per cycle; a lower-priority event that arrives in
        // the same cycle is dropped.
        if (ev_clr_a) begin
          op_a_d   = '0;
          flag_a_d = 1'b0;
          flag_c_d = 1'b0;
          state_d  = ST_LCD_WAIT;
        end else if (ev_clr_b) begin
          op_b_d   = '0;
          flag_b_d = 1'b0;
          flag_c_d = 1'b0;
          state_d  = ST_LCD_WAIT;
        end else if (ev_key_c) begin
          if (flag_a_q && flag_b_q) begin
            op_sel_d = bus.op_in;
            cnt_d    = CNT_INIT;
            state_d  = ST_SETTLE;
          end
        end else if (ev_key_a) begin
          op_a_d   = bus.keypad_val;
          flag_a_d = 1'b1;
          state_d  = ST_LCD_WAIT;
        end else if (ev_key_b) begin
          op_b_d   = bus.keypad_val;
          flag_b_d = 1'b1;
          state_d  = ST_LCD_WAIT;
        end
      end

      ST_SETTLE: begin
        // A clear aborts the compute. Load/compute presses are discarded.
        if (ev_clr_a) begin
          op_a_d   = '0;
          flag_a_d = 1'b0;
          flag_c_d = 1'b0;
          state_d  = ST_LCD_WAIT;
        end else if (ev_clr_b) begin
          op_b_d   = '0;
          flag_b_d = 1'b0;
          flag_c_d = 1'b0;
          state_d  = ST_LCD_WAIT;
        end else if (cnt_q == 4'd0) begin
          state_d = ST_CAPTURE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      ST_CAPTURE: begin
        reg_c_d  = cap_val;
        flag_c_d = 1'b1;
        state_d  = ST_LCD_WAIT;
      end

      ST_LCD_WAIT: begin
        if (bus.lcd_ack) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist_q    <= '0;
      arm_cnt_q <= '0;
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      op_a_q    <= '0;
      op_b_q    <= '0;
      op_sel_q  <= 1'b1;
      reg_c_q   <= '0;
      flag_a_q  <= 1'b0;
      flag_b_q  <= 1'b0;
      flag_c_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      hist_q    <= hist_d;
      arm_cnt_q <= arm_cnt_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      op_sel_q  <= op_sel_d;
      reg_c_q   <= reg_c_d;
      flag_a_q  <= flag_a_d;
      flag_b_q  <= flag_b_d;
      flag_c_q  <= flag_c_d;
    end
  end

  assign bus.op_a    = op_a_q;
  assign bus.op_b    = op_b_q;
  assign bus.op_sel  = op_sel_q;
  assign bus.reg_c   = reg_c_q;
  assign bus.flag_a  = flag_a_q;
  assign bus.flag_b  = flag_b_q;
  assign bus.flag_c  = flag_c_q;
  assign bus.busy    = (state_q != ST_IDLE);
  assign bus.lcd_req = (state_q == ST_LCD_WAIT);

endmodule

// File: tb/tb_fp16_calc_sequencer.sv
// tb_fp16_calc_sequencer -- self-checking bench for fp16_calc_sequencer.
// Builds with or without FP16_SPECIAL_EN; the expected capture values follow
// the macro.
module tb_fp16_calc_sequencer;

  localparam int S = 3;

  typedef enum logic [2:0] {ACT_LOAD_A, ACT_LOAD_B, ACT_CLR_A, ACT_CLR_B, ACT_CALC, ACT_AB} act_e;

  typedef struct {
    act_e        act;
    logic [15:0] val;
    logic        op;
    logic [15:0] res;
    int          ack_dly;
    logic [15:0] e_a, e_b, e_c;
    logic        e_sel, e_fa, e_fb, e_fc, e_lcd;
  } vec_t;

  logic        clk;
  logic        reset;
  logic        dp_fixed_en;
  logic [15:0] dp_fixed;
  int          n_vec, n_bad;

  // Behavioural model of the visible register state.
  logic [15:0] m_a, m_b, m_c;
  logic        m_sel, m_fa, m_fb, m_fc;

  fp16_calc_sequencer_if bus ();

  fp16_calc_sequencer #(.SETTLE_CYCLES(S), .KEY_SYNC(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for the combinational FP16 adder: any deterministic mix of its inputs.
  function automatic logic [15:0] fake_dp(input logic [15:0] a, input logic [15:0] b, input logic s);
    return (a ^ {b[7:0], b[15:8]}) + {15'd0, s} + 16'h1357;
  endfunction

  assign bus.res_in = dp_fixed_en ? dp_fixed : fake_dp(bus.op_a, bus.op_b, bus.op_sel);

  // Value the sequencer should capture into C for these operands.
  function automatic logic [15:0] ref_result(input logic [15:0] a, input logic [15:0] b,
                                             input logic op, input logic [15:0] res);
`ifdef FP16_SPECIAL_EN
    if (a[14:10] == 5'h1F || b[14:10] == 5'h1F) return 16'h7E00;
    if (a[14:0] == 15'd0) return op ? b : {~b[15], b[14:0]};
    if (b[14:0] == 15'd0) return a;
`endif
    return res;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, got, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic [15:0] ea, input logic [15:0] eb,
                             input logic [15:0] ec, input logic esel, input logic efa,
                             input logic efb, input logic efc);
    check({tag, ".op_a"},   bus.op_a,   ea);
    check({tag, ".op_b"},   bus.op_b,   eb);
    check({tag, ".reg_c"},  bus.reg_c,  ec);
    check({tag, ".op_sel"}, bus.op_sel, esel);
    check({tag, ".flag_a"}, bus.flag_a, efa);
    check({tag, ".flag_b"}, bus.flag_b, efb);
    check({tag, ".flag_c"}, bus.flag_c, efc);
  endtask

  // Ack the pending LCD request after dly cycles; the request must be held
  // until the ack and be gone the cycle after.
  task automatic ack_lcd(input string tag, input int dly);
    for (int i = 0; i < dly; i++) begin
      check({tag, ".req_held"}, bus.lcd_req, 1'b1);
      tick();
    end
    bus.lcd_ack = 1'b1;
    tick();
    bus.lcd_ack = 1'b0;
    check({tag, ".req_drop"}, bus.lcd_req, 1'b0);
    check({tag, ".idle"},     bus.busy,    1'b0);
  endtask

  // Press the button(s) for one action and follow it until the LCD request,
  // returning whether a request came and its delay from the busy rise.
  task automatic do_act(input string tag, input act_e act, input logic [15:0] val, input logic op,
                        input int ack_dly, output logic seen, output int lat);
    int   busy_at, req_at;
    logic busy_drop;
    busy_at = -1; req_at = -1; busy_drop = 1'b0;
    bus.keypad_val = val;
    bus.op_in      = op;
    case (act)
      ACT_LOAD_A: bus.key_a   = 1'b1;
      ACT_LOAD_B: bus.key_b   = 1'b1;
      ACT_CLR_A:  bus.clear_a = 1'b1;
      ACT_CLR_B:  bus.clear_b = 1'b1;
      ACT_CALC:   bus.key_c   = 1'b1;
      default: begin bus.key_a = 1'b1; bus.key_b = 1'b1; end
    endcase
    tick();
    bus.key_a = 1'b0; bus.key_b = 1'b0; bus.key_c = 1'b0;
    bus.clear_a = 1'b0; bus.clear_b = 1'b0;
    for (int i = 0; i < 16 && req_at < 0; i++) begin
      tick();
      if (bus.busy && busy_at < 0) begin
        busy_at = i;
        bus.op_in = ~op;                 // must not reach op_sel mid-compute
      end else if (busy_at >= 0 && !bus.busy) begin
        busy_drop = 1'b1;
      end
      if (bus.lcd_req) req_at = i;
    end
    bus.keypad_val = ~val;
    seen = (req_at >= 0);
    lat  = seen ? req_at - busy_at : -1;
    check({tag, ".busy_hold"}, busy_drop, 1'b0);
    if (seen) ack_lcd(tag, ack_dly);
    else check({tag, ".not_busy"}, bus.busy, 1'b0);
  endtask

  // Update the model for an action, run it and compare everything.
  task automatic apply(input string tag, input act_e act, input logic [15:0] val,
                       input logic op, input int ack_dly);
    logic exp_lcd, seen;
    int   exp_lat, lat;
    exp_lcd = 1'b1; exp_lat = 0;
    case (act)
      ACT_LOAD_A, ACT_AB: begin m_a = val; m_fa = 1'b1; end
      ACT_LOAD_B: begin m_b = val; m_fb = 1'b1; end
      ACT_CLR_A:  begin m_a = '0; m_fa = 1'b0; m_fc = 1'b0; end
      ACT_CLR_B:  begin m_b = '0; m_fb = 1'b0; m_fc = 1'b0; end
      default: begin
        if (m_fa && m_fb) begin
          m_sel = op;
          m_c   = ref_result(m_a, m_b, op, dp_fixed_en ? dp_fixed : fake_dp(m_a, m_b, op));
          m_fc  = 1'b1;
          exp_lat = S + 1;
        end else begin
          exp_lcd = 1'b0;
        end
      end
    endcase
    do_act(tag, act, val, op, ack_dly, seen, lat);
    check({tag, ".lcd"}, seen, exp_lcd);
    if (exp_lcd) check({tag, ".latency"}, lat, exp_lat);
    check_state(tag, m_a, m_b, m_c, m_sel, m_fa, m_fb, m_fc);
  endtask

  function automatic logic [15:0] rand_val();
    case ($urandom_range(0, 4))
      0:       return 16'h0000;
      1:       return 16'h8000;
      2:       return {1'b0, 5'h1F, 10'($urandom)};
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, n_vec=%0d", n_vec);
    $fatal(1, "timeout");
  end

  initial begin
    vec_t        tbl [12];
    logic [15:0] c7, c9;
    logic        seen, any;
    int          lat, n;

    n_vec = 0; n_bad = 0;
    dp_fixed_en = 1'b1; dp_fixed = 16'h0000;
    bus.key_a = 1'b0; bus.key_b = 1'b0; bus.key_c = 1'b0;
    bus.clear_a = 1'b0; bus.clear_b = 1'b0; bus.op_in = 1'b0;
    bus.keypad_val = 16'h0000; bus.lcd_ack = 1'b0;

`ifdef FP16_SPECIAL_EN
    c7 = 16'h7E00; c9 = 16'hC000;
`else
    c7 = 16'h1234; c9 = 16'h5555;
`endif
    //          act         val       op    res       ack  e_a       e_b       e_c       sel   fa    fb    fc    lcd
    tbl[0]  = '{ACT_LOAD_A, 16'h3C00, 1'b0, 16'h0000, 2,   16'h3C00, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[1]  = '{ACT_CALC,   16'h0000, 1'b0, 16'h9999, 0,   16'h3C00, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{ACT_LOAD_B, 16'h4000, 1'b0, 16'h0000, 1,   16'h3C00, 16'h4000, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[3]  = '{ACT_CALC,   16'h0000, 1'b1, 16'h4200, 0,   16'h3C00, 16'h4000, 16'h4200, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[4]  = '{ACT_CLR_A,  16'h0000, 1'b0, 16'h0000, 3,   16'h0000, 16'h4000, 16'h4200, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[5]  = '{ACT_CALC,   16'h0000, 1'b0, 16'h7777, 0,   16'h0000, 16'h4000, 16'h4200, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{ACT_LOAD_A, 16'h7C00, 1'b0, 16'h0000, 0,   16'h7C00, 16'h4000, 16'h4200, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[7]  = '{ACT_CALC,   16'h0000, 1'b1, 16'h1234, 1,   16'h7C00, 16'h4000, c7,       1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[8]  = '{ACT_LOAD_A, 16'h0000, 1'b1, 16'h0000, 0,   16'h0000, 16'h4000, c7,       1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[9]  = '{ACT_CALC,   16'h0000, 1'b0, 16'h5555, 2,   16'h0000, 16'h4000, c9,       1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[10] = '{ACT_CLR_B,  16'h0000, 1'b1, 16'h0000, 0,   16'h0000, 16'h0000, c9,       1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[11] = '{ACT_AB,     16'h2222, 1'b1, 16'h0000, 1,   16'h2222, 16'h0000, c9,       1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    // Reset with key_a held: reset values, and no event once reset releases.
    reset = 1'b0;
    bus.key_a = 1'b1; bus.keypad_val = 16'h1111;
    repeat (2) @(posedge clk);
    #1;
    check_state("reset", 16'h0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("reset.busy",    bus.busy,    1'b0);
    check("reset.lcd_req", bus.lcd_req, 1'b0);
    reset = 1'b1;
    any = 1'b0;
    repeat (8) begin
      tick();
      if (bus.busy || bus.lcd_req) any = 1'b1;
    end
    check("reset_hold.no_event", any, 1'b0);
    check("reset_hold.flag_a",   bus.flag_a, 1'b0);
    bus.key_a = 1'b0;
    repeat (4) tick();

    // lcd_ack outside LCD_WAIT is ignored.
    bus.lcd_ack = 1'b1;
    repeat (4) tick();
    bus.lcd_ack = 1'b0;
    check("idle_ack.busy", bus.busy, 1'b0);
    check("idle_ack.req",  bus.lcd_req, 1'b0);

    // Directed vector table.
    for (int v = 0; v < 12; v++) begin
      string tag;
      tag = $sformatf("vec%0d", v);
      dp_fixed = tbl[v].res;
      do_act(tag, tbl[v].act, tbl[v].val, tbl[v].op, tbl[v].ack_dly, seen, lat);
      check({tag, ".lcd"}, seen, tbl[v].e_lcd);
      if (tbl[v].e_lcd)
        check({tag, ".latency"}, lat, (tbl[v].act == ACT_CALC) ? S + 1 : 0);
      check_state(tag, tbl[v].e_a, tbl[v].e_b, tbl[v].e_c, tbl[v].e_sel,
                  tbl[v].e_fa, tbl[v].e_fb, tbl[v].e_fc);
    end
    m_a = tbl[11].e_a; m_b = tbl[11].e_b; m_c = tbl[11].e_c; m_sel = tbl[11].e_sel;
    m_fa = tbl[11].e_fa; m_fb = tbl[11].e_fb; m_fc = tbl[11].e_fc;

    // Clear_b during SETTLE aborts the compute.
    dp_fixed = 16'hBEEF;
    apply("abort.ld_a", ACT_LOAD_A, 16'h3C00, 1'b0, 0);
    apply("abort.ld_b", ACT_LOAD_B, 16'h4000, 1'b0, 0);
    bus.op_in = 1'b1; bus.key_c = 1'b1;
    tick();
    bus.key_c = 1'b0;
    n = 0;
    while (!bus.busy && n < 8) begin tick(); n++; end
    check("abort.busy_seen", bus.busy, 1'b1);
    bus.clear_b = 1'b1;
    tick();
    bus.clear_b = 1'b0;
    n = 1;
    while (!bus.lcd_req && n < 12) begin tick(); n++; end
    check("abort.latency", n, 3);
    m_b = '0; m_fb = 1'b0; m_fc = 1'b0; m_sel = 1'b1;
    check_state("abort", m_a, m_b, m_c, m_sel, m_fa, m_fb, m_fc);
    ack_lcd("abort", 1);
    any = 1'b0;
    repeat (6) begin tick(); if (bus.lcd_req) any = 1'b1; end
    check("abort.no_late_capture", any, 1'b0);
    check("abort.reg_c_after", bus.reg_c, m_c);

    // key_b while waiting for the LCD is discarded.
    bus.keypad_val = 16'hABCD; bus.key_a = 1'b1;
    tick();
    bus.key_a = 1'b0;
    n = 0;
    while (!bus.lcd_req && n < 12) begin tick(); n++; end
    check("busy_key.req", bus.lcd_req, 1'b1);
    m_a = 16'hABCD; m_fa = 1'b1;
    bus.keypad_val = 16'h1111; bus.key_b = 1'b1;
    tick();
    bus.key_b = 1'b0;
    repeat (4) tick();
    ack_lcd("busy_key", 0);
    any = 1'b0;
    repeat (6) begin tick(); if (bus.lcd_req) any = 1'b1; end
    check("busy_key.no_replay", any, 1'b0);
    check_state("busy_key", m_a, m_b, m_c, m_sel, m_fa, m_fb, m_fc);

    // Randomised actions against the model, datapath driven by fake_dp.
    dp_fixed_en = 1'b0;
    for (int i = 0; i < 60; i++) begin
      act_e a;
      int   r;
      r = int'($urandom_range(0, 9));
      if (r < 3)      a = ACT_LOAD_A;
      else if (r < 6) a = ACT_LOAD_B;
      else if (r < 7) a = ACT_CLR_A;
      else if (r < 8) a = ACT_CLR_B;
      else            a = ACT_CALC;
      apply($sformatf("rnd%0d", i), a, rand_val(), 1'($urandom), int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
